seq_alu: RTL and testbench

- Parametrised, handshaked successor to the single-cycle 32-bit ALU of the MIPS datapath. Executes AND/OR/NOR/ADD/SUB/SLT in one cycle, and MULTU/DIVU iteratively into HI/LO.
- Sits between the ALU-control decode and the writeback/HI-LO stage of the multi-cycle datapath.
- Operands are captured on a valid/ready handshake. The result is held until the consumer accepts it.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/seq_alu_if.sv | 32 +++
 rtl/seq_alu_muldiv.sv | 111 +++++++++++
 rtl/seq_alu.sv | 167 ++++++++++++++++
 tb/tb_seq_alu.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for seq_alu.
//   - Op-code constants (OP_AND .. OP_DIV).
//   - FSM state encoding (ST_IDLE / ST_BUSY / ST_DONE).
//   - Op classification helpers.
// Build option: define SEQ_ALU_SIGNED_EN to enable the signed MULT/DIV ops.
//   When it is undefined, codes 1010/1011 decode as illegal.
package alu_pkg;

`ifdef SEQ_ALU_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MULT  = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic is_signed_op(input logic [3:0] op);
        return SIGNED_EN && (op == OP_MULT || op == OP_DIV);
    endfunction

    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU) || is_signed_op(op);
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIVU) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle for seq_alu.
//   Request : in_valid, in_ready, alu_op, a, b, flush
//   Response: out_valid, out_ready, res_lo, res_hi, zero, cout, ovf, err
//   master = producer/consumer side, slave = the ALU.
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic             zero;
    logic             cout;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, alu_op, a, b, flush, out_ready,
        input  in_ready, out_valid, res_lo, res_hi, zero, cout, ovf, err
    );

    modport slave (
        input  in_valid, alu_op, a, b, flush, out_ready,
        output in_ready, out_valid, res_lo, res_hi, zero, cout, ovf, err
    );
endinterface

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative multiply / restoring-divide datapath.
//   clk, rst_n   : clock, async active-low reset
//   start_i      : load operands and begin WIDTH iterations
//   flush_i      : abandon the operation in flight
//   div_i/sgn_i  : divide (else multiply) / signed operands
//   a_i, b_i     : operands
//   last_o       : the current cycle performs the final step
//   lo_o, hi_o   : sign-corrected result after this cycle's step (valid with last_o)
module seq_alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic             div_i,
    input  logic             sgn_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // acc: product high / partial remainder; sh: multiplier / quotient shifter
    logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opd_q, opd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d;
    logic [WIDTH:0]   add_sum, part, shifted, diff;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    always_comb begin
        acc_d   = acc_q;
        sh_d    = sh_q;
        opd_d   = opd_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_p_d = neg_p_q;
        neg_r_d = neg_r_q;
        add_sum = {1'b0, acc_q} + {1'b0, opd_q};
        part    = sh_q[0] ? add_sum : {1'b0, acc_q};
        shifted = {acc_q, sh_q[WIDTH-1]};
        diff    = shifted - {1'b0, opd_q};
        if (start_i) begin
            acc_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            div_d   = div_i;
            sh_d    = div_i ? mag(a_i, sgn_i) : mag(b_i, sgn_i);
            opd_d   = div_i ? mag(b_i, sgn_i) : mag(a_i, sgn_i);
            neg_p_d = sgn_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r_d = sgn_i && div_i && a_i[WIDTH-1];
        end else if (flush_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (div_q) begin
                // Restoring step: keep the subtraction only if it did not borrow.
                if (!diff[WIDTH]) begin
                    acc_d = diff[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = shifted[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = part[WIDTH:1];
                sh_d  = {part[0], sh_q[WIDTH-1:1]};
            end
        end
    end

    // Sign correction is applied combinationally so it lands with the final step.
    always_comb begin
        prod = {acc_d, sh_d};
        if (neg_p_q) prod = ~prod + 1'b1;
        if (div_q) begin
            lo_o = neg_p_q ? (~sh_d + 1'b1) : sh_d;
            hi_o = neg_r_q ? (~acc_d + 1'b1) : acc_d;
        end else begin
            lo_o = prod[WIDTH-1:0];
            hi_o = prod[2*WIDTH-1:WIDTH];
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            sh_q    <= '0;
            opd_q   <= '0;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_p_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opd_q   <= opd_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_p_q <= neg_p_d;
            neg_r_q <= neg_r_d;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU. Logic/add/sub/slt complete in one cycle; MULTU/DIVU
// (and MULT/DIV when SEQ_ALU_SIGNED_EN is defined) iterate WIDTH cycles into HI/LO.
//   clk, rst_n : clock, async active-low reset
//   bus        : seq_alu_if.slave (operand request, result response, flush)
// Build option: SEQ_ALU_SIGNED_EN (see alu_pkg).
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
    logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d, err_q, err_d;
    logic             pend_ovf_q, pend_ovf_d;

    logic [3:0]       op;
    logic [WIDTH-1:0] a, b, bx;
    logic             is_sub, go_iter, div_ovf, slt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_lo, sc_hi;
    logic             sc_cout, sc_ovf, sc_err;
    logic             md_start, md_last;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign op      = bus.alu_op;
    assign a       = bus.a;
    assign b       = bus.b;
    assign is_sub  = (op == OP_SUB) || (op == OP_SLT);
    assign bx      = is_sub ? ~b : b;
    assign sum     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    // Signs differ: a is less iff a is negative; otherwise the difference sign decides.
    assign slt     = (a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1];
    // Division by zero short-circuits; everything else iterative takes the slow path.
    assign go_iter = is_iterative(op) && !(is_div_op(op) && (b == '0));
    // Signed most-negative / -1 is the only quotient that cannot be represented.
    assign div_ovf = is_signed_op(op) && is_div_op(op) &&
                     (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    always_comb begin
        sc_lo   = '0;
        sc_hi   = '0;
        sc_cout = 1'b0;
        sc_ovf  = 1'b0;
        sc_err  = 1'b0;
        case (op)
            OP_AND: sc_lo = a & b;
            OP_OR:  sc_lo = a | b;
            OP_NOR: sc_lo = ~(a | b);
            OP_ADD, OP_SUB: begin
                sc_lo   = sum[WIDTH-1:0];
                sc_cout = sum[WIDTH];
                sc_ovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: begin
                sc_lo   = {{(WIDTH-1){1'b0}}, slt};
                sc_cout = sum[WIDTH];
            end
            default: begin
                sc_err = 1'b1;
                // Only divide-by-zero reaches here among iterative ops.
                if (is_iterative(op)) begin
                    sc_lo = '1;
                    sc_hi = a;
                end
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        res_lo_d   = res_lo_q;
        res_hi_d   = res_hi_q;
        zero_d     = zero_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        pend_ovf_d = pend_ovf_q;
        md_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && !bus.flush) begin
                    if (go_iter) begin
                        md_start   = 1'b1;
                        pend_ovf_d = div_ovf;
                        state_d    = ST_BUSY;
                    end else begin
                        res_lo_d = sc_lo;
                        res_hi_d = sc_hi;
                        zero_d   = (sc_lo == '0);
                        cout_d   = sc_cout;
                        ovf_d    = sc_ovf;
                        err_d    = sc_err;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else if (md_last) begin
                    res_lo_d = md_lo;
                    res_hi_d = md_hi;
                    zero_d   = (md_lo == '0);
                    cout_d   = 1'b0;
                    ovf_d    = pend_ovf_q;
                    err_d    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.flush || bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    seq_alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(md_start),
        .flush_i(bus.flush),
        .div_i  (is_div_op(op)),
        .sgn_i  (is_signed_op(op)),
        .a_i    (a),
        .b_i    (b),
        .last_o (md_last),
        .lo_o   (md_lo),
        .hi_o   (md_hi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            zero_q     <= 1'b0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            pend_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_lo_q   <= res_lo_d;
            res_hi_q   <= res_hi_d;
            zero_q     <= zero_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
            pend_ovf_q <= pend_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.res_lo    = res_lo_q;
    assign bus.res_hi    = res_hi_q;
    assign bus.zero      = zero_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized self-checking bench for seq_alu (WIDTH = 32) against an
// arithmetic reference model; directed cases cover reset, flush and backpressure.
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_model(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] lo,
                                      output logic [31:0] hi, output logic [3:0] flags,
                                      output int lat);
        longint sa, sb, sr, ua, ub;
        logic [63:0] p;
        logic z, c, o, e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        lo = 0; hi = 0; c = 0; o = 0; e = 0; lat = 1;
        case (op)
            4'b0000: lo = a & b;
            4'b0001: lo = a | b;
            4'b1100: lo = ~(a | b);
            4'b0010: begin
                lo = a + b;
                c  = (ua + ub) > 64'sd4294967295;
                sr = sa + sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0110: begin
                lo = a - b;
                c  = (a >= b);
                sr = sa - sb;
                o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0111: begin
                lo = {31'b0, sa < sb};
                c  = (a >= b);
            end
            4'b1000: begin
                p = 64'(a) * 64'(b);
                lo = p[31:0]; hi = p[63:32]; lat = 33;
            end
            4'b1001: begin
                if (b == 0) begin lo = '1; hi = a; e = 1; end
                else begin lo = a / b; hi = a % b; lat = 33; end
            end
`ifdef SEQ_ALU_SIGNED_EN
            4'b1010: begin
                p = 64'(sa * sb);
                lo = p[31:0]; hi = p[63:32]; lat = 33;
            end
            4'b1011: begin
                if (b == 0) begin lo = '1; hi = a; e = 1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = a; hi = 0; o = 1; lat = 33;
                end else begin
                    lo = 32'(sa / sb); hi = 32'(sa % sb); lat = 33;
                end
            end
`endif
            default: e = 1;
        endcase
        z = (lo == 0);
        flags = {z, c, o, e};
    endfunction

    // Issue one op, wait for the result, hold it for 'hold' cycles, then accept it.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] elo, ehi;
        logic [3:0]  eflags;
        int          elat, lat;
        logic        busy_ok;
        ref_model(op, a, b, elo, ehi, eflags, elat);
        @(negedge clk);
        check($sformatf("in_ready_idle op%h", op), 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.a        = a;
        bus.b        = b;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency op%h a%h b%h", op, a, b), 64'(lat), 64'(elat));
        if (elat > 1) check($sformatf("busy_in_ready op%h", op), 64'(busy_ok), 64'd1);
        check($sformatf("res_lo op%h a%h b%h", op, a, b), 64'(bus.res_lo), 64'(elo));
        check($sformatf("res_hi op%h a%h b%h", op, a, b), 64'(bus.res_hi), 64'(ehi));
        check($sformatf("flags_zcoe op%h a%h b%h", op, a, b),
              64'({bus.zero, bus.cout, bus.ovf, bus.err}), 64'(eflags));
        check($sformatf("done_in_ready op%h", op), 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold op%h", op),
                  {bus.out_valid, bus.in_ready, bus.zero, bus.err, bus.res_lo, bus.res_hi[27:0]},
                  {1'b1, 1'b0, eflags[3], eflags[0], elo, ehi[27:0]});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check($sformatf("release op%h", op), 64'({bus.out_valid, bus.in_ready}), 64'b01);
    endtask

    logic [3:0] op_tab [13] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'h9,
                               4'hA, 4'hB, 4'h5, 4'h3, 4'hF};

    initial begin
        logic seen;
        logic [31:0] ra, rb;
        bus.in_valid = 0; bus.alu_op = 0; bus.a = 0; bus.b = 0;
        bus.flush = 0; bus.out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({bus.out_valid, bus.in_ready, bus.zero, bus.cout, bus.ovf,
                                 bus.err}), 64'b010000);
        check("reset_res", {bus.res_hi, bus.res_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'h2, 32'h7FFF_FFFF, 32'h1, 0);
        run_op(4'h6, 32'd5, 32'd5, 0);
        run_op(4'h7, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'h9, 32'd100, 32'd7, 0);
        run_op(4'h9, 32'd9, 32'd0, 0);
        run_op(4'h5, 32'h1234, 32'h5678, 0);
        run_op(4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 10);
        run_op(4'h8, 32'h1234_5678, 32'h0, 0);
`ifdef SEQ_ALU_SIGNED_EN
        run_op(4'hB, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(4'hB, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(4'hA, 32'hFFFF_FFFD, 32'd7, 0);
`endif

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.in_valid = 1; bus.alu_op = 4'h8; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1357;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_busy_ctrl", 64'({bus.out_valid, bus.in_ready, bus.zero, bus.cout, bus.ovf,
                                    bus.err}), 64'b010000);
        check("rst_busy_res", {bus.res_hi, bus.res_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'h8, 32'hDEAD_BEEF, 32'h1357, 0);

        // Flush during a divide: the result must never appear.
        @(negedge clk);
        bus.in_valid = 1; bus.alu_op = 4'h9; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.flush = 1;
        @(posedge clk);
        #1;
        bus.flush = 0;
        check("flush_busy_idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1;
        end
        check("flush_busy_no_valid", 64'(seen), 64'd0);

        // Flush while a result waits in DONE.
        @(negedge clk);
        bus.in_valid = 1; bus.alu_op = 4'h1; bus.a = 32'h1; bus.b = 32'h2;
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        @(negedge clk);
        bus.flush = 1;
        @(posedge clk);
        #1;
        bus.flush = 0;
        check("flush_done_idle", 64'({bus.out_valid, bus.in_ready}), 64'b01);

        // Flush beats in_valid in IDLE.
        @(negedge clk);
        bus.in_valid = 1; bus.flush = 1; bus.alu_op = 4'h2; bus.a = 32'd3; bus.b = 32'd4;
        @(posedge clk);
        #1;
        bus.in_valid = 0; bus.flush = 0;
        check("flush_idle_no_accept", 64'({bus.out_valid, bus.in_ready}), 64'b01);

        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 0;
                1: rb = $urandom_range(1, 15);
                2: ra = {1'b1, 31'b0};
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(op_tab[$urandom_range(0, 12)], ra, rb, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
